// File: rtl/lbuf_pkg.sv
// lbuf_pkg: shared types and default constants for the sprite line-buffer
// scan-out engine.
//   lbuf_state_e : IDLE (waiting for a line strobe) / SCAN (playing a bank out)
//   DEF_*        : default geometry and transparent colour code
package lbuf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } lbuf_state_e;

  localparam int         DEF_HW       = 9;
  localparam int         DEF_DW       = 8;
  localparam int         DEF_H_ACTIVE = 288;
  localparam logic [7:0] DEF_CLR_VAL  = 8'h0F;

endpackage

// File: rtl/lbuf_scanout_if.sv
// lbuf_scanout_if: read/write port of the 1024 x 8 sprite line buffer.
//   LB_AD : address {bank, x}, HW+1 bits
//   LB_WR : write strobe (clear-after-read)
//   LB_DI : write data
//   LB_DO : read data, one cycle registered latency from LB_AD
// Modports: master = scan-out engine, slave = line buffer RAM.
interface lbuf_scanout_if
  import lbuf_pkg::*;
#(
  parameter int HW = DEF_HW,
  parameter int DW = DEF_DW
);

  logic [HW:0]   LB_AD;
  logic          LB_WR;
  logic [DW-1:0] LB_DI;
  logic [DW-1:0] LB_DO;

  modport master (output LB_AD, output LB_WR, output LB_DI, input LB_DO);
  modport slave  (input LB_AD, input LB_WR, input LB_DI, output LB_DO);

endinterface

// File: rtl/lbuf_scanout.sv
// lbuf_scanout: read-side engine of the double-banked sprite line buffer.
// Plays bank RD_BANK out one pixel per PCLK_EN while the sprite writer fills
// the other bank; each pixel is read and then overwritten with CLR_VAL so the
// bank comes back empty when the banks swap on LINE_STB.
//
// Ports:
//   CL        in   system clock
//   RESET     in   synchronous active-high reset
//   LINE_STB  in   line start: swap banks, restart the scan (aborts a scan)
//   PCLK_EN   in   pixel enable, at most one pulse per two CL cycles
//   lb        master port to the line buffer RAM (LB_AD/LB_WR/LB_DI/LB_DO)
//   PIX_OUT   out  registered pixel to the mixer
//   PIX_VLD   out  one-cycle pulse when PIX_OUT carries a scanned pixel
//   RD_BANK   out  bank being scanned; the writer uses ~RD_BANK
//   BUSY      out  high while scanning
//
// Build option: LBUF_CLEAR_EN enables the clear-after-read write. Without it
// LB_WR is tied low and the writer must overwrite every pixel itself; read
// timing and PIX_OUT latency are identical in both builds.
//
// state | meaning
// IDLE  | no line in progress, PIX_OUT parked at CLR_VAL
// SCAN  | x walks 0..H_ACTIVE-1; phase 0 = read issued, phase 1 = clear
module lbuf_scanout
  import lbuf_pkg::*;
#(
  parameter int            HW       = DEF_HW,
  parameter int            DW       = DEF_DW,
  parameter int            H_ACTIVE = DEF_H_ACTIVE,
  parameter logic [DW-1:0] CLR_VAL  = DW'(DEF_CLR_VAL)
) (
  input  logic            CL,
  input  logic            RESET,
  input  logic            LINE_STB,
  input  logic            PCLK_EN,
  lbuf_scanout_if.master  lb,
  output logic [DW-1:0]   PIX_OUT,
  output logic            PIX_VLD,
  output logic            RD_BANK,
  output logic            BUSY
);

  localparam logic [HW-1:0] X_LAST = HW'(H_ACTIVE - 1);

  lbuf_state_e   state;
  logic          phase;
  logic [HW-1:0] x;
  logic          idle_pen;

  // The address is held for both the read and the following clear, so it is
  // simply the bank/x flops; x only moves after the clear has been issued.
  assign lb.LB_AD = {RD_BANK, x};
  assign lb.LB_DI = CLR_VAL;
  assign BUSY     = (state == SCAN);

`ifdef LBUF_CLEAR_EN
  assign lb.LB_WR = phase;
`else
  assign lb.LB_WR = 1'b0;
`endif

  always_ff @(posedge CL) begin
    if (RESET) begin
      state    <= IDLE;
      phase    <= 1'b0;
      x        <= '0;
      RD_BANK  <= 1'b0;
      PIX_OUT  <= CLR_VAL;
      PIX_VLD  <= 1'b0;
      idle_pen <= 1'b0;
    end else begin
      PIX_VLD  <= 1'b0;
      // In IDLE the pixel slot still advances with PCLK_EN: the last scanned
      // pixel is shown for one pixel period, then PIX_OUT parks at CLR_VAL
      // with the same two-cycle latency as scanned pixels.
      idle_pen <= PCLK_EN && (state == IDLE) && !LINE_STB;
      if (idle_pen)
        PIX_OUT <= CLR_VAL;

      if (state == SCAN && phase) begin
        // Read data is valid now; the clear is being written this cycle.
        PIX_OUT <= lb.LB_DO;
        PIX_VLD <= 1'b1;
        phase   <= 1'b0;
        if (x == X_LAST) begin
          x     <= '0;
          state <= IDLE;
        end else begin
          x <= x + 1'b1;
        end
      end else if (state == SCAN && PCLK_EN && !LINE_STB) begin
        phase <= 1'b1;
      end

      // A strobe overrides the scan position but lets an in-flight clear and
      // its pixel complete, since the RAM write happens on this same edge.
      if (LINE_STB) begin
        RD_BANK <= ~RD_BANK;
        x       <= '0;
        phase   <= 1'b0;
        state   <= SCAN;
      end
    end
  end

endmodule

// File: tb/tb_lbuf_scanout.sv
module tb_lbuf_scanout;

  localparam int         HA  = 288;
  localparam logic [7:0] CLR = 8'h0F;
`ifdef LBUF_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       CL = 1'b0;
  logic       RESET = 1'b1;
  logic       LINE_STB = 1'b0;
  logic       PCLK_EN = 1'b0;
  logic [7:0] PIX_OUT;
  logic       PIX_VLD;
  logic       RD_BANK;
  logic       BUSY;

  lbuf_scanout_if #(.HW(9), .DW(8)) lb ();

  lbuf_scanout #(.HW(9), .DW(8), .H_ACTIVE(HA), .CLR_VAL(CLR)) dut (
    .CL(CL), .RESET(RESET), .LINE_STB(LINE_STB), .PCLK_EN(PCLK_EN),
    .lb(lb), .PIX_OUT(PIX_OUT), .PIX_VLD(PIX_VLD), .RD_BANK(RD_BANK),
    .BUSY(BUSY)
  );

  always #5 CL = ~CL;

  int cyc = 0;
  always @(posedge CL) cyc <= cyc + 1;

  // Line buffer RAM: registered read, write on LB_WR, bulk bank preload.
  logic [7:0] ram   [1024];
  logic [7:0] stage [1024];
  logic [7:0] rd_q;
  bit         load_req = 1'b0;
  int         load_sel = 0;
  assign lb.LB_DO = rd_q;
  always @(posedge CL) begin
    rd_q <= ram[lb.LB_AD];
    if (lb.LB_WR) ram[lb.LB_AD] <= lb.LB_DI;
    if (load_req)
      for (int i = 0; i < 512; i++) ram[load_sel*512+i] <= stage[load_sel*512+i];
  end

  // Reference model: expected buffer contents plus per-cycle expectations.
  logic [7:0] gold [1024];
  logic [7:0] pix_evt [int];
  bit         vld_evt [int];
  int         ad_at   [int];
  bit         wr_at   [int];
  bit         busy_at [int];
  bit         bank_at [int];
  bit m_active = 1'b0, m_bank = 1'b0, m_pend = 1'b0;
  int m_p = 0;
  int chk_start = 32'h7fff_ffff;

  int tests = 0, failed = 0;
  logic [7:0] cur_pix = CLR;
  logic [7:0] vq [$];
  int wr_cnt = 0, bad_cnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Rules: a pixel enable is taken while a line is active, no strobe is
  // present and the previous cycle did not take one. Pixel i of the line
  // appears two cycles later with the pre-clear buffer value; the cycle after
  // acceptance is the clear. After pixel H-1 clears the line ends.
  task automatic model(input int n, input bit r, input bit s, input bit p);
    bit in_clr;
    int a;
    if (r) begin
      m_active = 0; m_bank = 0; m_p = 0; m_pend = 0;
      pix_evt[n+1] = CLR;
      if (vld_evt.exists(n+1)) vld_evt.delete(n+1);
      if (chk_start == 32'h7fff_ffff) chk_start = n + 1;
    end else begin
      in_clr = m_pend;
      if (!m_active && p && !s) pix_evt[n+2] = CLR;
      if (m_active && p && !s && !in_clr) begin
        a = int'(m_bank) * 512 + m_p;
        pix_evt[n+2] = gold[a];
        vld_evt[n+2] = 1'b1;
        if (CLR_EN) gold[a] = CLR;
        m_pend = 1;
      end else if (in_clr) begin
        m_pend = 0;
        if (m_p == HA - 1) begin m_active = 0; m_p = 0; end
        else m_p = m_p + 1;
      end
      if (s) begin m_bank = !m_bank; m_p = 0; m_active = 1; m_pend = 0; end
    end
    ad_at[n+1]   = int'(m_bank) * 512 + m_p;
    wr_at[n+1]   = m_pend && CLR_EN;
    busy_at[n+1] = m_active;
    bank_at[n+1] = m_bank;
  endtask

  task automatic compare_cycle();
    if (cyc >= chk_start && ad_at.exists(cyc)) begin
      if (pix_evt.exists(cyc)) cur_pix = pix_evt[cyc];
      check("pix_out", PIX_OUT, cur_pix);
      check("pix_vld", PIX_VLD, vld_evt.exists(cyc));
      check("lb_ad", lb.LB_AD, ad_at[cyc]);
      check("lb_wr", lb.LB_WR, wr_at[cyc]);
      check("lb_di", lb.LB_DI, CLR);
      check("busy", BUSY, busy_at[cyc]);
      check("rd_bank", RD_BANK, bank_at[cyc]);
    end
    if (PIX_VLD) vq.push_back(PIX_OUT);
    if (lb.LB_WR) wr_cnt++;
    if (lb.LB_AD[8:0] >= 9'(HA)) bad_cnt++;
  endtask

  task automatic step(input bit r, input bit s, input bit p);
    @(posedge CL); #1;
    RESET = r; LINE_STB = s; PCLK_EN = p;
    model(cyc, r, s, p);
    @(negedge CL);
    compare_cycle();
  endtask

  task automatic load_bank(input int b, input bit r);
    for (int i = 0; i < 512; i++) gold[b*512+i] = stage[b*512+i];
    load_sel = b; load_req = 1'b1;
    step(r, 1'b0, 1'b0);
    load_req = 1'b0;
  endtask

  byte unsigned t1_pix [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] keep [512];

  initial begin
    bit r, s, p;
    int last_pen, mism;
    for (int i = 0; i < 1024; i++) stage[i] = 8'($urandom);
    stage[512] = 8'h11; stage[513] = 8'h22; stage[514] = 8'h33; stage[515] = 8'h44;
    step(1'b1, 1'b0, 1'b0);
    load_bank(0, 1'b1);
    load_bank(1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("reset_pix", PIX_OUT, CLR);
    check("reset_busy", BUSY, 0);
    check("reset_bank", RD_BANK, 0);
    check("reset_ad", lb.LB_AD, 0);

    // Short line out of bank 1.
    vq.delete();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t1_bank", RD_BANK, 1);
    check("t1_count", vq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_pix", (i < vq.size()) ? int'(vq[i]) : -1, t1_pix[i]);
      check("t1_ram", ram[512+i], CLR_EN ? CLR : 8'(t1_pix[i]));
    end

    // Full line out of bank 0.
    step(1'b0, 1'b1, 1'b0);
    vq.delete(); wr_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < HA; i++) begin
      step(1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("full_busy", BUSY, 0);
    check("full_vld_count", vq.size(), HA);
    check("full_wr_count", wr_cnt, CLR_EN ? HA : 0);
    check("full_bad_addr", bad_cnt, 0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("full_idle_pix", PIX_OUT, CLR);

    // Back-to-back enables: second one is dropped.
    step(1'b0, 1'b1, 1'b0);
    vq.delete();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("b2b_vld_count", vq.size(), 1);
    check("b2b_ad", lb.LB_AD, 513);

    // Abort at x=100 during the clear phase.
    for (int i = 0; i < 512; i++) begin
      stage[i] = 8'($urandom);
      keep[i]  = stage[i];
    end
    load_bank(0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("abort_bank", RD_BANK, 1);
    check("abort_ad", lb.LB_AD, 512);
    check("abort_x99", ram[99], CLR_EN ? CLR : keep[99]);
    check("abort_x100", ram[100], CLR_EN ? CLR : keep[100]);
    mism = 0;
    for (int i = 101; i < 512; i++) if (ram[i] !== keep[i]) mism++;
    check("abort_tail_kept", mism, 0);

    // Reset at x=50.
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("rst_bank", RD_BANK, 0);
    check("rst_busy", BUSY, 0);
    check("rst_wr", lb.LB_WR, 0);
    check("rst_pix", PIX_OUT, CLR);
    check("rst_vld", PIX_VLD, 0);
    check("rst_ad", lb.LB_AD, 0);

    // Randomized traffic.
    last_pen = -10;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 1499) == 0);
      s = ($urandom_range(0, 899) == 0);
      if (i - last_pen == 1) p = ($urandom_range(0, 9) == 0);
      else p = 1'($urandom_range(0, 1));
      if (p) last_pen = i;
      step(r, s, p);
    end
    repeat (4) step(1'b0, 1'b0, 1'b0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== gold[i]) mism++;
    check("final_ram", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lbuf_scanout.md
Name: lbuf_scanout

Overview:
- Read-side engine for the sprite line buffer. It drives the buffer's read/write port (1024 x 8, two 512-entry banks) and plays one bank out as pixels while the sprite writer fills the other bank.
- Reads each pixel, then writes the transparent value back to the same address (clear-after-read), so the bank is empty when the banks swap.
- Sits between the line buffer RAM and the video mixer. It is locked to the video timing by a line strobe and a pixel enable.

Parameters:
- HW, 9, pixel X counter width; bank bit is added on top, so address width = HW+1.
- DW, 8, pixel data width.
- H_ACTIVE, 288, pixels scanned per line.
- CLR_VAL, 8'h0F, transparent colour code: written back on clear and output when idle.

Ports:
- CL, in, 1, system clock; only clock.
- RESET, in, 1, synchronous active-high reset.
- LINE_STB, in, 1, one-cycle pulse at line start: swap banks and start the scan.
- PCLK_EN, in, 1, pixel enable; at most one pulse per 2 CL cycles.
- LB_AD, out, HW+1, line buffer address: {RD_BANK, x}.
- LB_WR, out, 1, line buffer write strobe (clear).
- LB_DI, out, DW, line buffer write data; always CLR_VAL.
- LB_DO, in, DW, line buffer read data; RAM has 1-cycle registered read latency.
- PIX_OUT, out, DW, registered pixel to the mixer.
- PIX_VLD, out, 1, one-cycle pulse when PIX_OUT updates with scanned data.
- RD_BANK, out, 1, bank being scanned; the writer uses ~RD_BANK.
- BUSY, out, 1, high while in SCAN.

Behaviour:
- Reset values: state IDLE, phase 0, x=0, RD_BANK=0, LB_AD=0, LB_WR=0, PIX_OUT=CLR_VAL, PIX_VLD=0, BUSY=0.
- States:
  - IDLE: LB_WR=0, PIX_OUT held at CLR_VAL.
  - SCAN: x runs 0..H_ACTIVE-1.
  - Phase bit within SCAN: 0 = RD, 1 = CLR.
- IDLE -> SCAN on LINE_STB: RD_BANK toggles, x=0, phase=0.
- SCAN, phase 0, cycle t:
  - Requires PCLK_EN=1 at t.
  - Drive LB_AD={RD_BANK,x}, LB_WR=0; phase -> 1.
- SCAN, phase 1, cycle t+1:
  - LB_DO now valid; same LB_AD; LB_WR=1, LB_DI=CLR_VAL.
  - PIX_OUT <= LB_DO (visible at t+2); PIX_VLD=1 at t+2.
  - Phase -> 0 and x <= x+1.
  - If x==H_ACTIVE-1: go to IDLE, with PIX_OUT returning to CLR_VAL one pixel period later.
- Latency: PCLK_EN to PIX_OUT is exactly 2 CL cycles.
- PCLK_EN during phase 1 is a protocol violation. It is ignored: x does not advance, no extra read.
- LINE_STB during SCAN aborts the line:
  - A phase-1 clear in that same cycle still completes.
  - Next cycle RD_BANK toggles, x=0, phase=0.
  - Uncleared tail pixels of the aborted bank stay as written.
- LINE_STB and PCLK_EN in the same phase-0 cycle: the strobe wins and no read is issued.
- Wrap: x never exceeds H_ACTIVE-1. Addresses H_ACTIVE..511 of a bank are never read or cleared by this block.
- RESET mid-scan: immediate return to reset values. Buffer contents are untouched.

Optional Feature:
- Macro LBUF_CLEAR_EN.
- Defined: clear-after-read as above (LB_WR=1 in phase 1).
- Undefined:
  - LB_WR is tied to 0 and the phase-1 write is suppressed.
  - Read timing and PIX_OUT latency are unchanged.
  - The sprite writer must overwrite every pixel itself.

Decomposition:
- Package lbuf_pkg holds:
  - State enum (IDLE, SCAN).
  - Default constants: H_ACTIVE=288, CLR_VAL=8'h0F, HW=9, DW=8.
- No sub-module: x counter, phase bit and bank flop are inline in one always block plus output logic.

Test Plan:
- Reset then one line: preload bank 1 addr 0..3 = 8'h11,22,33,44; LINE_STB; PCLK_EN every 4 cycles.
  - RD_BANK=1; PIX_OUT sequence 11,22,33,44, each 2 cycles after its PCLK_EN.
  - Bank 1 addr 0..3 read back 8'h0F afterwards.
- Full line: after 288 pixel enables, BUSY falls, state IDLE, PIX_OUT=8'h0F.
  - No access to addr 288..511; LB_WR pulse count = 288.
- Back-to-back PCLK_EN in consecutive cycles: second pulse dropped, x advances by 1 only, one PIX_VLD.
- LINE_STB at x=100 during phase 1:
  - Clear at {bank,100} still written.
  - Next cycle RD_BANK toggles, LB_AD={~bank,0}; pixels 101..287 of the old bank are retained.
- RESET asserted at x=50: next cycle all outputs at reset values, RD_BANK=0, BUSY=0, LB_WR=0.
- LBUF_CLEAR_EN undefined: repeat the first test; PIX_OUT identical, LB_WR never 1, bank 1 addr 0..3 still 11,22,33,44.
